mips_harvard_mem: RTL
=====================

# mips_harvard_mem

Harvard memory responder that sits on the far side of the CPU's instruction and data buses. It serves zero-wait-state combinational reads on both ports and synchronous word writes on the data port. A valid/ready word-loader preloads program and data images before execution, and the block keeps sticky bus-error and access-count status for the testbench. It is the memory model used by all CPU-level benches.

## Interface
- IMEM_BASE, 32'hBFC00000, byte address of instruction word 0
- IMEM_AW, 10, log2 of instruction memory depth in words
- DMEM_BASE, 32'h00000000, byte address of data word 0
- DMEM_AW, 10, log2 of data memory depth in words
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- clk_enable  input  1  qualifies data writes (same signal as the CPU's clock_enable)
- instr_address  input  32  CPU instruction fetch byte address
- instr_readdata  output  32  fetched word
- data_address  input  32  CPU data byte address
- data_read  input  1  data read strobe
- data_write  input  1  data write strobe
- data_writedata  input  32  write word
- data_readdata  output  32  read word
- load_valid  input  1  loader word valid
- load_ready  output  1  loader can accept a word
- load_sel  input  1  0 = instruction memory, 1 = data memory
- load_data  input  32  loader word
- load_done  input  1  single-cycle pulse that ends the load phase
- running  output  1  block is in RUN
- bus_err  output  1  sticky out-of-window access flag
- rd_count  output  16  saturating count of accepted data reads
- wr_count  output  16  saturating count of accepted data writes

## Operation
- Byte lane convention, both ports: readdata = {byte A+3, A+2, A+1, A}, with byte A in bits 7:0. The CPU byte-swaps internally. Write lanes use the same convention.
- Addresses are word-aligned. Bits 1:0 are ignored.
- Word index = (addr - BASE) >> 2. An address is in-window when addr - BASE < 4 * 2^AW (unsigned 32-bit arithmetic).
- FSM states:
  - LOAD (entered on reset).
    - load_ready = 1 while the load pointer for load_sel is not full.
    - load_valid & load_ready writes load_data at the pointer for the selected memory, then increments that pointer.
    - Separate 0..2^AW pointers are kept for imem and dmem.
    - A pointer reaching 2^AW is full. load_ready = 0 for that memory, with no wrap.
    - CPU data writes are ignored in LOAD. Reads are served.
    - load_done moves to RUN. If load_done coincides with a handshake, the word is written first, then the block enters RUN.
  - RUN.
    - load_ready = 0.
    - data_write & clk_enable & in-window writes data_writedata.
    - Every accepted data_read (read strobe, any window) increments rd_count. Every data_write & clk_enable increments wr_count. Both counters saturate at 16'hFFFF.
    - Instruction memory is read-only in RUN.
- Out-of-window behaviour:
  - Reads return 32'h0.
  - Writes are dropped.
  - bus_err is set if the access is a strobed data access in RUN, or an instruction fetch in RUN.
  - Fetch of address 0 (the CPU halt address) does not set bus_err.
- Simultaneous data_read & data_write to the same word: data_readdata returns the pre-write contents. The new value is visible next cycle.
- Reset mid-load or mid-run:
  - Returns to LOAD.
  - Clears the pointers, counters and bus_err.
  - Memory contents are preserved, so a re-run needs no reload.
- Memory arrays have no reset. They are uninitialised (X) until loaded or written.

## Timing
- Reset values: running = 0, bus_err = 0, rd_count = 0, wr_count = 0. load_ready = 1 in the first cycle after reset. readdata outputs are combinational from the arrays.
- Read latency is 0 cycles, purely combinational from the address.
- Writes (data and loader) commit on the rising edge of clk.
- load_done is sampled at the edge. running rises in the cycle after the load_done edge.
- bus_err, rd_count and wr_count update at the edge following the access.

## Test plan
- Loader then fetch: load imem words 0x00000024, 0x11111111, pulse load_done, drive instr_address = 0xBFC00004 → instr_readdata = 0x11111111 combinationally, running = 1.
- Data write/read: in RUN, write 0xDEADBEEF to 0x00000010 with clk_enable = 1. Next cycle read 0x00000010 → 0xDEADBEEF, wr_count = 1, rd_count = 1.
- Same-cycle read+write: word 0x8 holds 0x1, write 0x2 while reading 0x8 → readdata = 0x1 that cycle, 0x2 the next.
- clk_enable gating and LOAD-phase writes: write with clk_enable = 0 in RUN → memory unchanged, wr_count unchanged. CPU write in LOAD → ignored.
- Window error: read 0x20000000 in RUN → readdata = 0, bus_err = 1 next cycle, sticky until reset. Fetch of 0x00000000 → bus_err stays 0.
- Load full and mid-run reset: with IMEM_AW = 2, after 4 imem words load_ready = 0 for load_sel = 0 but 1 for load_sel = 1. Assert reset in RUN → running = 0, counters = 0, a previously loaded word still reads back.

Source files
------------

// File: rtl/mips_harvard_mem.sv
// Harvard instruction/data memory responder with a valid/ready preload port and bench status.
// Latency: reads are combinational (0 cycles); data and loader writes commit on the rising clk edge.
// Backpressure: load_ready drops per memory once its load pointer is full, and is always low in RUN.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   instr_address/_readdata - instruction fetch port (read-only once running)
//   data_address, data_read, data_write, data_writedata, data_readdata, clk_enable - data port
//   load_valid/ready/sel/data, load_done - word loader (sel 0 = imem, 1 = dmem), done ends LOAD
//   running, bus_err, rd_count, wr_count - phase and sticky status for the bench
module mips_harvard_mem #(
  parameter logic [31:0] IMEM_BASE = 32'hBFC00000,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] DMEM_BASE = 32'h00000000,
  parameter int          DMEM_AW   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        load_sel,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        running,
  output logic        bus_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t state, state_nxt;

  logic [31:0] imem [0:(1<<IMEM_AW)-1];
  logic [31:0] dmem [0:(1<<DMEM_AW)-1];

  // Pointers are one bit wider than the index so "full" (== 2^AW) is just the MSB.
  logic [IMEM_AW:0] i_ptr;
  logic [DMEM_AW:0] d_ptr;
  logic             i_full, d_full;

  logic [31:0]        i_off, d_off;
  logic               i_in_win, d_in_win;
  logic [IMEM_AW-1:0] i_idx;
  logic [DMEM_AW-1:0] d_idx;

  logic load_fire, dwr_fire, err_set;

  // Unsigned offset from the base: anything below the base wraps to a huge value,
  // so one range test covers both sides of the window.
  assign i_off    = instr_address - IMEM_BASE;
  assign d_off    = data_address - DMEM_BASE;
  assign i_in_win = (i_off >> (IMEM_AW + 2)) == 32'd0;
  assign d_in_win = (d_off >> (DMEM_AW + 2)) == 32'd0;
  assign i_idx    = i_off[IMEM_AW+1:2];
  assign d_idx    = d_off[DMEM_AW+1:2];

  assign i_full = i_ptr[IMEM_AW];
  assign d_full = d_ptr[DMEM_AW];

  assign instr_readdata = i_in_win ? imem[i_idx] : 32'h0;
  assign data_readdata  = d_in_win ? dmem[d_idx] : 32'h0;

  assign running = (state == S_RUN);

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    if (state == S_LOAD) begin
      load_ready = load_sel ? !d_full : !i_full;
      if (load_done) state_nxt = S_RUN;
    end
  end

  assign load_fire = !reset && load_valid && load_ready;
  assign dwr_fire  = !reset && running && data_write && clk_enable && d_in_win;

  // Fetching the halt address (0) is the CPU's normal way to stop, not a fault.
  assign err_set = running &&
                   (((data_read || data_write) && !d_in_win) ||
                    (!i_in_win && (instr_address[31:2] != 30'd0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LOAD;
      i_ptr    <= '0;
      d_ptr    <= '0;
      bus_err  <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      state <= state_nxt;
      if (load_fire && !load_sel) i_ptr <= i_ptr + (IMEM_AW+1)'(1);
      if (load_fire &&  load_sel) d_ptr <= d_ptr + (DMEM_AW+1)'(1);
      if (err_set) bus_err <= 1'b1;
      if (running && data_read && (rd_count != 16'hFFFF))
        rd_count <= rd_count + 16'd1;
      if (running && data_write && clk_enable && (wr_count != 16'hFFFF))
        wr_count <= wr_count + 16'd1;
    end
  end

  // Arrays are deliberately outside the reset so a re-run after reset needs no reload.
  always_ff @(posedge clk) begin
    if (load_fire && !load_sel) imem[i_ptr[IMEM_AW-1:0]] <= load_data;
  end

  // Loader and CPU writes are exclusive by phase (LOAD vs RUN).
  always_ff @(posedge clk) begin
    if (load_fire && load_sel)
      dmem[d_ptr[DMEM_AW-1:0]] <= load_data;
    else if (dwr_fire)
      dmem[d_idx] <= data_writedata;
  end

endmodule
